// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control block: field widths,
// state codes, opcode/funct constants, write_pc and alu_op encodings, and the
// one-hot instruction class produced by the decoder.
package multicycle_control_pkg;

    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;
    localparam int CNT_W   = 32;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [FUNCT_W-1:0] FN_JR = 6'b001000;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    // Exactly one bit set per decoded instruction.
    typedef struct packed {
        logic r_alu;
        logic jr;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic i_arith;   // addi/addiu/slti/sltiu
        logic i_logic;   // andi/ori/xori/lui
        logic unknown;
    } instr_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Handshake bundle between the control FSM and the fetch/datapath side.
//   master : the controller (drives enables, PC select, status)
//   slave  : fetch + datapath (drives IR fields, zero flag, stall, counter preload)
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               stall;
    logic               cnt_load;       // preload retired counter (debug/bring-up)
    logic [CNT_W-1:0]   cnt_load_val;

    logic               write_ir;
    logic [1:0]         write_pc;
    logic               branch;
    logic               n_branch;
    logic               jmp;
    logic               jal;
    logic               jrn;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               link_write;
    logic [1:0]         alu_op;
    logic [2:0]         state;
    logic               instr_done;
    logic [CNT_W-1:0]   retired_cnt;

    modport master (
        input  opcode, funct, zero, stall, cnt_load, cnt_load_val,
        output write_ir, write_pc, branch, n_branch, jmp, jal, jrn,
               reg_write, reg_dst, mem_to_reg, alu_src, mem_read, mem_write,
               link_write, alu_op, state, instr_done, retired_cnt
    );

    modport slave (
        output opcode, funct, zero, stall, cnt_load, cnt_load_val,
        input  write_ir, write_pc, branch, n_branch, jmp, jal, jrn,
               reg_write, reg_dst, mem_to_reg, alu_src, mem_read, mem_write,
               link_write, alu_op, state, instr_done, retired_cnt
    );

endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational opcode/funct -> one-hot instruction class.
//   opcode, funct : instruction fields (live IR in ID, captured copy later)
//   cls           : one-hot class; unknown opcodes set cls.unknown
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    output instr_class_t       cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_JR) cls.jr    = 1'b1;
                else                cls.r_alu = 1'b1;
            end
            OP_LW:  cls.lw  = 1'b1;
            OP_SW:  cls.sw  = 1'b1;
            OP_BEQ: cls.beq = 1'b1;
            OP_BNE: cls.bne = 1'b1;
            OP_J:   cls.j   = 1'b1;
            OP_JAL: cls.jal = 1'b1;
            6'b001000, 6'b001001, 6'b001010, 6'b001011: cls.i_arith = 1'b1;
            6'b001100, 6'b001101, 6'b001110, 6'b001111: cls.i_logic = 1'b1;
            default: cls.unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM feeding instruction_fetch and the datapath.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : master side of multicycle_control_if (IR fields, zero, stall
//              and counter preload in; PC select, type flags, datapath
//              enables, debug state, instr_done and retired_cnt out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IF  0 | latch IR, PC+4
// ID  1 | decode live IR; jumps/jr resolve here; capture opcode/funct
// EX  2 | ALU op; branches resolve on zero
// MEM 3 | load read / store write
// WB  4 | register file write (ALU result, load data, or jal link)
// 5-7   | illegal: outputs 0, back to IF
//
// Outputs are decoded from the state register rather than re-registered:
// the ID decision depends on the IR that fetch latches at the end of IF,
// and the branch PC select depends on zero during EX, so neither is known
// a cycle early.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_e             state_q, state_d, nxt;
    logic [OP_W-1:0]    opc_q, opc_d, dec_opc;
    logic [FUNCT_W-1:0] fn_q, fn_d, dec_fn;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    instr_class_t       cls;

    logic       write_ir, branch, n_branch, jmp, jal, jrn;
    logic       reg_write, reg_dst, mem_to_reg, alu_src, mem_read, mem_write, link_write;
    logic [1:0] write_pc, alu_op;
    logic       done;

    // ID decodes the IR directly; later states use the copy taken at end of ID.
    assign dec_opc = (state_q == ST_ID) ? bus.opcode : opc_q;
    assign dec_fn  = (state_q == ST_ID) ? bus.funct  : fn_q;

    multicycle_control_decode u_decode (
        .opcode (dec_opc),
        .funct  (dec_fn),
        .cls    (cls)
    );

    always_comb begin
        write_ir   = 1'b0;
        write_pc   = PC_HOLD;
        branch     = 1'b0;
        n_branch   = 1'b0;
        jmp        = 1'b0;
        jal        = 1'b0;
        jrn        = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        link_write = 1'b0;
        alu_op     = ALU_ADD;
        nxt        = ST_IF;

        case (state_q)
            ST_IF: begin
                write_ir = 1'b1;
                write_pc = PC_INC;
                nxt      = ST_ID;
            end
            ST_ID: begin
                if (cls.j) begin
                    jmp      = 1'b1;
                    write_pc = PC_JUMP;
                end else if (cls.jal) begin
                    jal      = 1'b1;
                    write_pc = PC_JUMP;
                    nxt      = ST_WB;
                end else if (cls.jr) begin
                    jrn      = 1'b1;
                    write_pc = PC_JUMP;
                end else if (!cls.unknown) begin
                    nxt = ST_EX;
                end
            end
            ST_EX: begin
                if (cls.beq) begin
                    branch   = 1'b1;
                    alu_op   = ALU_SUB;
                    write_pc = bus.zero ? PC_BRANCH : PC_HOLD;
                end else if (cls.bne) begin
                    n_branch = 1'b1;
                    alu_op   = ALU_SUB;
                    write_pc = bus.zero ? PC_HOLD : PC_BRANCH;
                end else if (cls.lw || cls.sw) begin
                    alu_src = 1'b1;
                    nxt     = ST_MEM;
                end else if (cls.r_alu) begin
                    alu_op  = ALU_FUNCT;
                    reg_dst = 1'b1;
                    nxt     = ST_WB;
                end else if (cls.i_arith || cls.i_logic) begin
                    alu_src = 1'b1;
                    alu_op  = cls.i_logic ? ALU_LOGIC : ALU_ADD;
                    nxt     = ST_WB;
                end
            end
            ST_MEM: begin
                // Address path (alu_src) held so the memory address stays stable.
                alu_src = 1'b1;
                if (cls.lw) begin
                    mem_read = 1'b1;
                    nxt      = ST_WB;
                end else begin
                    mem_write = cls.sw;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = cls.r_alu;   // select rd as destination for R-type
                mem_to_reg = cls.lw;
                link_write = cls.jal;
            end
            default: nxt = ST_IF;
        endcase

        done = (nxt == ST_IF) && (state_q inside {ST_ID, ST_EX, ST_MEM, ST_WB});

        if (bus.stall) begin
            write_ir   = 1'b0;
            write_pc   = PC_HOLD;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            link_write = 1'b0;
            jal        = 1'b0;
            done       = 1'b0;
        end

        state_d = bus.stall ? state_q : nxt;
        opc_d   = (state_q == ST_ID && !bus.stall) ? bus.opcode : opc_q;
        fn_d    = (state_q == ST_ID && !bus.stall) ? bus.funct  : fn_q;
        cnt_d   = bus.cnt_load ? bus.cnt_load_val
                               : cnt_q + {{(CNT_W-1){1'b0}}, done};

        // State resets to IF, whose decode would raise write_ir; keep
        // everything quiet while reset is held.
        if (rst) begin
            write_ir   = 1'b0;
            write_pc   = PC_HOLD;
            branch     = 1'b0;
            n_branch   = 1'b0;
            jmp        = 1'b0;
            jal        = 1'b0;
            jrn        = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            link_write = 1'b0;
            alu_op     = ALU_ADD;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IF;
            opc_q   <= '0;
            fn_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            fn_q    <= fn_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.write_ir    = write_ir;
    assign bus.write_pc    = write_pc;
    assign bus.branch      = branch;
    assign bus.n_branch    = n_branch;
    assign bus.jmp         = jmp;
    assign bus.jal         = jal;
    assign bus.jrn         = jrn;
    assign bus.reg_write   = reg_write;
    assign bus.reg_dst     = reg_dst;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.alu_src     = alu_src;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.link_write  = link_write;
    assign bus.alu_op      = alu_op;
    assign bus.state       = state_q;
    assign bus.instr_done  = done;
    assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // fl = {branch, n_branch, jmp, jal, jrn}
    // en = {reg_write, reg_dst, mem_to_reg, alu_src, mem_read, mem_write, link_write}
    typedef struct packed {
        logic [2:0] st;
        logic       wir;
        logic [1:0] wpc;
        logic [4:0] fl;
        logic [6:0] en;
        logic [1:0] aop;
        logic       done;
    } outs_t;

    typedef struct {
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic        zero;
        logic        stall;
        outs_t       exp;
        logic [31:0] cnt;
    } vec_t;

    localparam outs_t O_IF = '{st:3'd0, wir:1'b1, wpc:2'b01, fl:5'd0, en:7'd0, aop:2'd0, done:1'b0};
    localparam outs_t O_ID = '{st:3'd1, wir:1'b0, wpc:2'b00, fl:5'd0, en:7'd0, aop:2'd0, done:1'b0};
    localparam outs_t O_ZERO = '0;

    localparam logic [5:0] R = 6'b000000, ADD = 6'b100000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010, JAL = 6'b000011;
    localparam logic [5:0] JR = 6'b001000, ORI = 6'b001101, BAD = 6'b111111;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic outs_t o(input logic [2:0] st, input logic wir, input logic [1:0] wpc,
                                input logic [4:0] fl, input logic [6:0] en,
                                input logic [1:0] aop, input logic done);
        outs_t r;
        r.st = st; r.wir = wir; r.wpc = wpc; r.fl = fl; r.en = en; r.aop = aop; r.done = done;
        return r;
    endfunction

    function automatic outs_t observe();
        outs_t r;
        r.st   = bus.state;
        r.wir  = bus.write_ir;
        r.wpc  = bus.write_pc;
        r.fl   = {bus.branch, bus.n_branch, bus.jmp, bus.jal, bus.jrn};
        r.en   = {bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src,
                  bus.mem_read, bus.mem_write, bus.link_write};
        r.aop  = bus.alu_op;
        r.done = bus.instr_done;
        return r;
    endfunction

    task automatic add(input logic [5:0] opc, input logic [5:0] fn, input logic zero,
                       input logic stall, input outs_t e, input logic [31:0] c);
        vec_t v;
        v.opc = opc; v.fn = fn; v.zero = zero; v.stall = stall; v.exp = e; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input outs_t exp, input logic [31:0] exp_cnt);
        logic [20:0] act_bits;
        logic [20:0] exp_bits;
        act_bits = observe();
        exp_bits = exp;
        total++;
        if (act_bits !== exp_bits) begin
            bad++;
            $display("FAIL %s outputs: got %h expected %h", name, act_bits, exp_bits);
        end
        total++;
        if (bus.retired_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL %s retired_cnt: got %h expected %h", name, bus.retired_cnt, exp_cnt);
        end
    endtask

    task automatic drive(input logic [5:0] opc, input logic [5:0] fn, input logic zero, input logic stall);
        bus.opcode = opc;
        bus.funct  = fn;
        bus.zero   = zero;
        bus.stall  = stall;
    endtask

    // Drive inputs for one cycle, check at the falling edge, move just past the next rising edge.
    task automatic step(input string name, input logic [5:0] opc, input logic [5:0] fn,
                        input logic zero, input logic stall, input outs_t e, input logic [31:0] c);
        drive(opc, fn, zero, stall);
        @(negedge clk);
        check(name, e, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // R add; opcode changed in EX/WB to prove the captured copy is used
        add(R, ADD, 0, 0, O_IF, 0);
        add(R, ADD, 0, 0, O_ID, 0);
        add(J, 6'h3f, 0, 0, o(3'd2, 0, 2'b00, 5'b00000, 7'b0100000, 2'b10, 0), 0);
        add(J, 6'h3f, 0, 0, o(3'd4, 0, 2'b00, 5'b00000, 7'b1100000, 2'b00, 1), 0);
        // lw: 5 cycles
        add(LW, 0, 0, 0, O_IF, 1);
        add(LW, 0, 0, 0, O_ID, 1);
        add(LW, 0, 0, 0, o(3'd2, 0, 2'b00, 5'b00000, 7'b0001000, 2'b00, 0), 1);
        add(LW, 0, 0, 0, o(3'd3, 0, 2'b00, 5'b00000, 7'b0001100, 2'b00, 0), 1);
        add(LW, 0, 0, 0, o(3'd4, 0, 2'b00, 5'b00000, 7'b1010000, 2'b00, 1), 1);
        // sw: 4 cycles
        add(SW, 0, 0, 0, O_IF, 2);
        add(SW, 0, 0, 0, O_ID, 2);
        add(SW, 0, 0, 0, o(3'd2, 0, 2'b00, 5'b00000, 7'b0001000, 2'b00, 0), 2);
        add(SW, 0, 0, 0, o(3'd3, 0, 2'b00, 5'b00000, 7'b0001010, 2'b00, 1), 2);
        // beq taken / not taken; zero in ID set opposite to show it is ignored
        add(BEQ, 0, 0, 0, O_IF, 3);
        add(BEQ, 0, 0, 0, O_ID, 3);
        add(BEQ, 0, 1, 0, o(3'd2, 0, 2'b11, 5'b10000, 7'b0000000, 2'b01, 1), 3);
        add(BEQ, 0, 0, 0, O_IF, 4);
        add(BEQ, 0, 1, 0, O_ID, 4);
        add(BEQ, 0, 0, 0, o(3'd2, 0, 2'b00, 5'b10000, 7'b0000000, 2'b01, 1), 4);
        // bne taken / not taken
        add(BNE, 0, 0, 0, O_IF, 5);
        add(BNE, 0, 1, 0, O_ID, 5);
        add(BNE, 0, 0, 0, o(3'd2, 0, 2'b11, 5'b01000, 7'b0000000, 2'b01, 1), 5);
        add(BNE, 0, 0, 0, O_IF, 6);
        add(BNE, 0, 0, 0, O_ID, 6);
        add(BNE, 0, 1, 0, o(3'd2, 0, 2'b00, 5'b01000, 7'b0000000, 2'b01, 1), 6);
        // jal: ID -> WB, link in WB
        add(JAL, 0, 0, 0, O_IF, 7);
        add(JAL, 0, 0, 0, o(3'd1, 0, 2'b10, 5'b00010, 7'b0000000, 2'b00, 0), 7);
        add(R, ADD, 0, 0, o(3'd4, 0, 2'b00, 5'b00000, 7'b1000001, 2'b00, 1), 7);
        // jr: 2 cycles
        add(R, JR, 0, 0, O_IF, 8);
        add(R, JR, 0, 0, o(3'd1, 0, 2'b10, 5'b00001, 7'b0000000, 2'b00, 1), 8);
        // j: 2 cycles
        add(J, 0, 0, 0, O_IF, 9);
        add(J, 0, 0, 0, o(3'd1, 0, 2'b10, 5'b00100, 7'b0000000, 2'b00, 1), 9);
        // unknown opcode retires as a NOP from ID
        add(BAD, 0, 0, 0, O_IF, 10);
        add(BAD, 0, 0, 0, o(3'd1, 0, 2'b00, 5'b00000, 7'b0000000, 2'b00, 1), 10);
        // ori: I-format logic
        add(ORI, 0, 0, 0, O_IF, 11);
        add(ORI, 0, 0, 0, O_ID, 11);
        add(ORI, 0, 0, 0, o(3'd2, 0, 2'b00, 5'b00000, 7'b0001000, 2'b11, 0), 11);
        add(ORI, 0, 0, 0, o(3'd4, 0, 2'b00, 5'b00000, 7'b1000000, 2'b00, 1), 11);
        // stalls: in IF, 3 cycles in EX, in WB
        add(R, ADD, 0, 1, O_ZERO, 12);
        add(R, ADD, 0, 0, O_IF, 12);
        add(R, ADD, 0, 0, O_ID, 12);
        add(R, ADD, 0, 1, o(3'd2, 0, 2'b00, 5'b00000, 7'b0100000, 2'b10, 0), 12);
        add(R, ADD, 0, 1, o(3'd2, 0, 2'b00, 5'b00000, 7'b0100000, 2'b10, 0), 12);
        add(R, ADD, 0, 1, o(3'd2, 0, 2'b00, 5'b00000, 7'b0100000, 2'b10, 0), 12);
        add(R, ADD, 0, 0, o(3'd2, 0, 2'b00, 5'b00000, 7'b0100000, 2'b10, 0), 12);
        add(R, ADD, 0, 1, o(3'd4, 0, 2'b00, 5'b00000, 7'b0100000, 2'b00, 0), 12);
        add(R, ADD, 0, 0, o(3'd4, 0, 2'b00, 5'b00000, 7'b1100000, 2'b00, 1), 12);

        rst = 1'b1;
        bus.cnt_load     = 1'b0;
        bus.cnt_load_val = '0;
        drive(R, ADD, 0, 0);
        repeat (2) @(negedge clk);
        check("reset_held", O_ZERO, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i].opc, vecs[i].fn, vecs[i].zero,
                 vecs[i].stall, vecs[i].exp, vecs[i].cnt);

        // Async reset in the middle of a load's MEM cycle.
        step("lw2_if", LW, 0, 0, 0, O_IF, 13);
        step("lw2_id", LW, 0, 0, 0, O_ID, 13);
        step("lw2_ex", LW, 0, 0, 0, o(3'd2, 0, 2'b00, 5'b00000, 7'b0001000, 2'b00, 0), 13);
        check("lw2_mem", o(3'd3, 0, 2'b00, 5'b00000, 7'b0001100, 2'b00, 0), 13);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", O_ZERO, 0);
        @(negedge clk);
        check("rst_hold", O_ZERO, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(J, 0, 0, 0);
        step("post_rst_if", J, 0, 0, 0, O_IF, 0);
        step("post_rst_id", J, 0, 0, 0, o(3'd1, 0, 2'b10, 5'b00100, 7'b0000000, 2'b00, 1), 0);

        // Counter preload and wrap.
        bus.cnt_load     = 1'b1;
        bus.cnt_load_val = 32'hFFFF_FFFF;
        step("preload_if", J, 0, 0, 0, O_IF, 1);
        bus.cnt_load = 1'b0;
        step("wrap_id", J, 0, 0, 0, o(3'd1, 0, 2'b10, 5'b00100, 7'b0000000, 2'b00, 1), 32'hFFFF_FFFF);
        step("wrap_if", J, 0, 0, 0, O_IF, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
